// File: rtl/axi_lite_regbank_if.sv
// AXI-Lite interface bundle used between the arbiter and the register bank.
// It carries the AW, W, B, AR and R channels and has no clock or reset of its own.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_regbank.sv
// AXI-Lite slave register bank with independent AW/W buffers and a flat register export.
// Define REGBANK_RO_ID_EN to make register 0 a read-only ID register.
module axi_lite_regbank #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'h5245_4742
) (
  input  logic                         clk,
  input  logic                         rst_n,
  axi_lite_if.slave                    s_if,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int IDX_W  = $clog2(NUM_REGS);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Goes high on the first edge after reset release; gates all READYs.
  logic rst_done;

  logic             aw_full;
  logic [IDX_W-1:0] aw_idx;
  logic             aw_err;
  logic             w_full;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic             bvalid;
  resp_e            bresp;

  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  resp_e                 rresp;

  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [IDX_W-1:0]      aw_idx_in;
  logic [IDX_W-1:0]      ar_idx_in;
  logic                  aw_oor;
  logic                  ar_oor;
  logic                  aw_err_in;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [DATA_WIDTH-1:0] rd_data;
  resp_e                 rd_resp;

  assign aw_addr   = s_if.awaddr;
  assign ar_addr   = s_if.araddr;
  assign aw_idx_in = aw_addr[2 +: IDX_W];
  assign ar_idx_in = ar_addr[2 +: IDX_W];
  assign aw_oor    = (aw_addr >> (2 + IDX_W)) != '0;
  assign ar_oor    = (ar_addr >> (2 + IDX_W)) != '0;

`ifdef REGBANK_RO_ID_EN
  assign aw_err_in = aw_oor || (aw_idx_in == '0);
  // Register 0 storage is never written or read back in this build.
  logic unused_ok;
  assign unused_ok = ^regs[0];
`else
  assign aw_err_in = aw_oor;
`endif

  assign s_if.awready = rst_done && !aw_full && !bvalid;
  assign s_if.wready  = rst_done && !w_full  && !bvalid;
  assign s_if.arready = rst_done && !rvalid;
  assign s_if.bvalid  = bvalid;
  assign s_if.bresp   = bresp;
  assign s_if.rvalid  = rvalid;
  assign s_if.rdata   = rdata;
  assign s_if.rresp   = rresp;

  assign aw_hs  = s_if.awvalid && s_if.awready;
  assign w_hs   = s_if.wvalid  && s_if.wready;
  assign ar_hs  = s_if.arvalid && s_if.arready;
  assign commit = aw_full && w_full;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_W-1:0]     strb
  );
    merge_bytes = old_val;
    for (int k = 0; k < STRB_W; k++) begin
      if (strb[k]) merge_bytes[8*k +: 8] = new_val[8*k +: 8];
    end
  endfunction

  // Write path: the two buffer-full flags plus BVALID form the write state machine
  // (IDLE, HAVE_AW, HAVE_W, COMMIT, RESP).
  // NOTE: the register array is flops, not RAM, so it is cleared by the async reset
  // like every other piece of state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      aw_full  <= 1'b0;
      aw_idx   <= '0;
      aw_err   <= 1'b0;
      w_full   <= 1'b0;
      w_data   <= '0;
      w_strb   <= '0;
      bvalid   <= 1'b0;
      bresp    <= RESP_OKAY;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      // NOTE: state updates are non-blocking so every reader in this block sees
      // the pre-edge values regardless of statement order.
      rst_done <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_idx  <= aw_idx_in;
        aw_err  <= aw_err_in;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_if.wdata;
        w_strb <= s_if.wstrb;
      end
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_err ? RESP_SLVERR : RESP_OKAY;
        if (!aw_err) regs[aw_idx] <= merge_bytes(regs[aw_idx], w_data, w_strb);
      end else if (bvalid && s_if.bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (ar_oor) begin
      rd_resp = RESP_SLVERR;
    end else begin
      rd_data = regs[ar_idx_in];
`ifdef REGBANK_RO_ID_EN
      if (ar_idx_in == '0) rd_data = ID_VALUE;
`endif
    end
  end

  // Read data is taken from stored values, so a same-edge write returns the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= rd_data;
      rresp  <= rd_resp;
    end else if (rvalid && s_if.rready) begin
      rvalid <= 1'b0;
    end
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[DATA_WIDTH*i +: DATA_WIDTH] = regs[i];
`ifdef REGBANK_RO_ID_EN
    reg_q[DATA_WIDTH-1:0] = ID_VALUE;
`endif
  end

endmodule

// File: tb/tb_axi_lite_regbank.sv
// Directed self-checking bench for axi_lite_regbank (NUM_REGS = 8).
// Build with +define+REGBANK_RO_ID_EN to exercise the read-only ID register.
module tb_axi_lite_regbank;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [255:0] reg_q;
  logic [255:0] exp_q;
  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  axi_lite_regbank #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(8), .ID_VALUE(32'h5245_4742)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_if(bus), .reg_q(reg_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    exp_q = '0;
`ifdef REGBANK_RO_ID_EN
    exp_q[31:0] = 32'h5245_4742;
`endif
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp, output int lat);
    logic aw_go, w_go;
    int n;
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      aw_go = bus.awvalid && bus.awready;
      w_go  = bus.wvalid && bus.wready;
      tick();
      n++;
      if (aw_go) bus.awvalid = 1'b0;
      if (w_go)  bus.wvalid  = 1'b0;
    end
    check("wr_accept", {bus.awvalid, bus.wvalid}, 2'b00);
    lat = 0;
    while (!bus.bvalid && lat < 10) begin
      tick();
      lat++;
    end
    check("wr_bvalid", bus.bvalid, 1'b1);
    resp = bus.bresp;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("wr_bclear", bus.bvalid, 1'b0);
    check("wr_ready_back", {bus.awready, bus.wready}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    n = 0;
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!bus.arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    bus.arvalid = 1'b0;
    check("rd_rvalid", bus.rvalid, 1'b1);
    data = bus.rdata;
    resp = bus.rresp;
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    check("rd_rclear", bus.rvalid, 1'b0);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;

    bus.awvalid = 1'b0; bus.awaddr = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0;
    bus.rready = 1'b0;
    reset_model();

    // Reset: three cycles low, READYs rise on the first edge after release.
    repeat (3) tick();
    check("rst_readys", {bus.awready, bus.wready, bus.arready}, 3'b000);
    check("rst_valids", {bus.bvalid, bus.rvalid}, 2'b00);
    check("rst_resps", {bus.bresp, bus.rresp, bus.rdata}, '0);
    check("rst_reg_q", reg_q, exp_q);
    rst_n = 1'b1;
    #1;
    check("rel_readys_pre_edge", {bus.awready, bus.wready, bus.arready}, 3'b000);
    tick();
    check("rel_readys", {bus.awready, bus.wready, bus.arready}, 3'b111);

    // Write 0x8 then read it back; AW and W together give BVALID one edge later.
    do_write(32'h8, 32'hAAAA_5555, 4'hF, resp, lat);
    exp_q[95:64] = 32'hAAAA_5555;
    check("w8_latency", lat, 1);
    check("w8_bresp", resp, 2'b00);
    check("w8_reg_q", reg_q, exp_q);
    do_read(32'h8, data, resp);
    check("r8_data", data, 32'hAAAA_5555);
    check("r8_rresp", resp, 2'b00);

    // W arrives four cycles before AW.
    bus.wdata = 32'hDEAD_BEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    check("wfirst_wready_low", bus.wready, 1'b0);
    repeat (4) begin
      tick();
      check("wfirst_no_bvalid", bus.bvalid, 1'b0);
    end
    check("wfirst_reg_q_held", reg_q, exp_q);
    bus.awaddr = 32'h4; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("wfirst_bvalid_next", bus.bvalid, 1'b0);
    tick();
    exp_q[63:32] = 32'hDEAD_BEEF;
    check("wfirst_bvalid", bus.bvalid, 1'b1);
    check("wfirst_reg_q", reg_q, exp_q);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;

    // Byte strobes on reg2.
    do_write(32'h8, 32'h1122_3344, 4'hF, resp, lat);
    do_write(32'h8, 32'hFFFF_FFFF, 4'b0101, resp, lat);
    exp_q[95:64] = 32'h11FF_33FF;
    check("strb_bresp", resp, 2'b00);
    check("strb_reg_q", reg_q, exp_q);
    do_read(32'h8, data, resp);
    check("strb_rdata", data, 32'h11FF_33FF);

    // Out-of-range write under B backpressure.
    bus.awaddr = 32'h1000_0000; bus.awvalid = 1'b1;
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("oor_bvalid_hold", bus.bvalid, 1'b1);
      check("oor_bresp_hold", bus.bresp, 2'b10);
      check("oor_readys_low", {bus.awready, bus.wready}, 2'b00);
      tick();
    end
    check("oor_reg_q", reg_q, exp_q);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
    check("oor_bclear", bus.bvalid, 1'b0);
    do_read(32'h1000_0000, data, resp);
    check("oor_rdata", data, 32'h0);
    check("oor_rresp", resp, 2'b10);

    // Collision: AR to reg3 on the same edge reg3 commits 0x1.
    do_write(32'hC, 32'hCAFE_0003, 4'hF, resp, lat);
    exp_q[127:96] = 32'hCAFE_0003;
    bus.awaddr = 32'hC; bus.awvalid = 1'b1;
    bus.wdata = 32'h1; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    bus.araddr = 32'hC; bus.arvalid = 1'b1;
    check("coll_arready", bus.arready, 1'b1);
    tick();
    bus.arvalid = 1'b0;
    exp_q[127:96] = 32'h1;
    check("coll_rvalid", bus.rvalid, 1'b1);
    check("coll_rdata_old", bus.rdata, 32'hCAFE_0003);
    check("coll_bvalid", bus.bvalid, 1'b1);
    check("coll_reg_q", reg_q, exp_q);
    bus.bready = 1'b1; bus.rready = 1'b1;
    tick();
    bus.bready = 1'b0; bus.rready = 1'b0;
    check("coll_clear", {bus.bvalid, bus.rvalid}, 2'b00);

    // Reset with only AW accepted: AW must be discarded.
    bus.awaddr = 32'h10; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    check("mid_aw_held", bus.awready, 1'b0);
    rst_n = 1'b0;
    #1;
    reset_model();
    check("mid_rst_reg_q", reg_q, exp_q);
    tick();
    rst_n = 1'b1;
    tick();
    check("mid_post_bvalid", bus.bvalid, 1'b0);
    check("mid_post_readys", {bus.awready, bus.wready}, 2'b11);
    bus.wdata = 32'h55; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    tick();
    bus.wvalid = 1'b0;
    repeat (3) tick();
    check("mid_no_stale_commit", bus.bvalid, 1'b0);
    check("mid_reg_q_zero", reg_q, exp_q);
    bus.awaddr = 32'h10; bus.awvalid = 1'b1;
    tick();
    bus.awvalid = 1'b0;
    tick();
    exp_q[159:128] = 32'h55;
    check("mid_bvalid", bus.bvalid, 1'b1);
    check("mid_bresp", bus.bresp, 2'b00);
    check("mid_reg_q", reg_q, exp_q);
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;

    // Register 0: read-only ID or an ordinary register, depending on the build.
    do_write(32'h0, 32'h1357_9BDF, 4'hF, resp, lat);
`ifdef REGBANK_RO_ID_EN
    check("r0_bresp", resp, 2'b10);
    check("r0_reg_q", reg_q, exp_q);
    do_read(32'h0, data, resp);
    check("r0_rdata", data, 32'h5245_4742);
`else
    exp_q[31:0] = 32'h1357_9BDF;
    check("r0_bresp", resp, 2'b00);
    check("r0_reg_q", reg_q, exp_q);
    do_read(32'h0, data, resp);
    check("r0_rdata", data, 32'h1357_9BDF);
`endif
    check("r0_rresp", resp, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
